prog_loader: RTL and testbench

Synthesizable program/data loader that replaces simulation-only memory preloading for the RISC-V core. It accepts a valid/ready word stream of load blocks, writes each block into the instruction or data memory, and holds the core in reset until loading finishes. It sits between an external host stream (UART bridge or bench driver) and the instruction/data memory write ports, driving the core's reset.

---
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Stream-driven program/data loader: parses header/base/data blocks into IMEM/DMEM
// writes and holds the core in reset until a LAST block has fully landed.
module prog_loader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               core_rst_n,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        loaded_words
);

  localparam int unsigned AW_MAX = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
  localparam int unsigned SUM_W  = AW_MAX + 17;

  // S_WRAP holds release of core reset until the final write strobe has been issued.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_DATA,
    S_WRAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state, state_n;
  logic                blk_last;
  logic                blk_tgt;
  logic [15:0]         blk_n;
  logic [15:0]         remain;
  logic [AW_MAX-1:0]   cur_addr;
  logic [AW_MAX-1:0]   base_bits;
  logic [SUM_W-1:0]    base_sum;
  logic [SUM_W-1:0]    limit;
  logic                range_bad;
  logic                accept;
  logic                session_start;

  assign s_ready    = (state == S_HDR) || (state == S_ADDR) || (state == S_DATA);
  assign busy       = s_ready || (state == S_WRAP);
  assign done       = (state == S_DONE);
  assign core_rst_n = (state == S_DONE);
  assign err        = (state == S_ERR);

  assign accept        = s_valid && s_ready;
  assign session_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  always_comb begin
    base_bits = '0;
    limit     = '0;
    if (blk_tgt) begin
      base_bits = AW_MAX'(s_data[DMEM_AW-1:0]);
      limit     = SUM_W'(1) << DMEM_AW;
    end else begin
      base_bits = AW_MAX'(s_data[IMEM_AW-1:0]);
      limit     = SUM_W'(1) << IMEM_AW;
    end
    base_sum  = SUM_W'(base_bits) + SUM_W'(blk_n);
    range_bad = (base_sum > limit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_HDR;
      S_HDR:  if (accept) state_n = S_ADDR;
      S_ADDR: begin
        if (accept) begin
          if (range_bad)         state_n = S_ERR;
          else if (blk_n == '0)  state_n = blk_last ? S_DONE : S_HDR;
          else                   state_n = S_DATA;
        end
      end
      S_DATA: if (accept && (remain == 16'd1)) state_n = blk_last ? S_WRAP : S_HDR;
      S_WRAP: state_n = S_DONE;
      S_DONE: if (start) state_n = S_HDR;
      S_ERR:  if (start) state_n = S_HDR;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_last     <= 1'b0;
      blk_tgt      <= 1'b0;
      blk_n        <= '0;
      remain       <= '0;
      cur_addr     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      loaded_words <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (session_start) loaded_words <= '0;
      if (accept && (state == S_HDR)) begin
        blk_last <= s_data[31];
        blk_tgt  <= s_data[30];
        blk_n    <= s_data[15:0];
      end
      if (accept && (state == S_ADDR)) begin
        cur_addr <= base_bits;
        remain   <= blk_n;
      end
      if (accept && (state == S_DATA)) begin
        if (blk_tgt) begin
          dmem_we    <= 1'b1;
          dmem_addr  <= cur_addr[DMEM_AW-1:0];
          dmem_wdata <= s_data;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= cur_addr[IMEM_AW-1:0];
          imem_wdata <= s_data;
        end
        cur_addr     <= cur_addr + 1'b1;
        remain       <= remain - 16'd1;
        loaded_words <= loaded_words + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: block parsing, write timing, range error, reload, throttle, reset.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst_n, start, s_valid, s_ready;
  logic [31:0] s_data;
  logic        imem_we, dmem_we, core_rst_n, busy, done, err;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_wdata, dmem_wdata, loaded_words;

  always #5 clk = ~clk;

  prog_loader #(.DATA_W(32), .IMEM_AW(10), .DMEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err),
    .loaded_words(loaded_words)
  );

  int vectors = 0;
  int miscompares = 0;
  int overlaps = 0;
  logic        w_tgt[$];
  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  int n0;

  // Write log taken mid-cycle so strobes are stable.
  always @(negedge clk) begin
    if (imem_we && dmem_we) overlaps++;
    if (imem_we) begin w_tgt.push_back(1'b0); w_addr.push_back(32'(imem_addr)); w_data.push_back(imem_wdata); end
    if (dmem_we) begin w_tgt.push_back(1'b1); w_addr.push_back(32'(dmem_addr)); w_data.push_back(dmem_wdata); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w);
    int g;
    s_valid = 1'b1;
    s_data  = w;
    g = 0;
    while (!s_ready && g < 20) begin @(negedge clk); g++; end
    check("send_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_wr(input int idx, input logic tgt, input logic [31:0] a, input logic [31:0] d);
    check($sformatf("wr%0d_tgt", idx), 32'(w_tgt[idx]), 32'(tgt));
    check($sformatf("wr%0d_addr", idx), w_addr[idx], a);
    check($sformatf("wr%0d_data", idx), w_data[idx], d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_dmem_addr"}, 32'(dmem_addr), 32'd0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_loaded"}, loaded_words, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("idle_core_rst_n", 32'(core_rst_n), 32'd0);
    check("idle_s_ready", 32'(s_ready), 32'd0);

    // Single LAST IMEM block of four words
    n0 = w_addr.size();
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_s_ready", 32'(s_ready), 32'd1);
    send(32'h8000_0004);
    send(32'h0000_0000);
    send(32'h0000_0013);
    check("t1_first_we", 32'(imem_we), 32'd1);
    check("t1_first_addr", 32'(imem_addr), 32'd0);
    check("t1_first_data", imem_wdata, 32'h0000_0013);
    check("t1_first_dmem_we", 32'(dmem_we), 32'd0);
    send(32'h0010_0093);
    send(32'h0020_8113);
    send(32'h0000_006F);
    check("t1_last_we", 32'(imem_we), 32'd1);
    check("t1_last_addr", 32'(imem_addr), 32'd3);
    check("t1_done_early", 32'(done), 32'd0);
    check("t1_core_rst_early", 32'(core_rst_n), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_core_rst_n", 32'(core_rst_n), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_we_end", 32'(imem_we), 32'd0);
    check("t1_loaded", loaded_words, 32'd4);
    tick();
    check("t1_wr_count", 32'(w_addr.size() - n0), 32'd4);
    check_wr(n0 + 0, 1'b0, 32'd0, 32'h0000_0013);
    check_wr(n0 + 1, 1'b0, 32'd1, 32'h0010_0093);
    check_wr(n0 + 2, 1'b0, 32'd2, 32'h0020_8113);
    check_wr(n0 + 3, 1'b0, 32'd3, 32'h0000_006F);

    // Two blocks: IMEM non-last, then DMEM last
    pulse_start();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_core_rst_n", 32'(core_rst_n), 32'd0);
    check("t2_loaded_clr", loaded_words, 32'd0);
    n0 = w_addr.size();
    send(32'h0000_0002); send(32'h0000_0010); send(32'h0000_000A); send(32'h0000_000B);
    send(32'hC000_0003); send(32'h0000_0000);
    send(32'hDEAD_BEEF); send(32'h0000_0001); send(32'h0000_0002);
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_loaded", loaded_words, 32'd5);
    tick();
    check("t2_wr_count", 32'(w_addr.size() - n0), 32'd5);
    check_wr(n0 + 0, 1'b0, 32'h10, 32'h0000_000A);
    check_wr(n0 + 1, 1'b0, 32'h11, 32'h0000_000B);
    check_wr(n0 + 2, 1'b1, 32'h00, 32'hDEAD_BEEF);
    check_wr(n0 + 3, 1'b1, 32'h01, 32'h0000_0001);
    check_wr(n0 + 4, 1'b1, 32'h02, 32'h0000_0002);
    check("t2_overlap", 32'(overlaps), 32'd0);

    // Reload from DONE with an empty LAST block
    pulse_start();
    check("t3_core_rst_drop", 32'(core_rst_n), 32'd0);
    check("t3_done_clr", 32'(done), 32'd0);
    check("t3_loaded_clr", loaded_words, 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    send(32'h8000_0000);
    send(32'h0000_0005);
    check("t3_done", 32'(done), 32'd1);
    check("t3_core_rst_n", 32'(core_rst_n), 32'd1);
    check("t3_s_ready", 32'(s_ready), 32'd0);
    check("t3_loaded", loaded_words, 32'd0);

    // Range error: 0x3FF + 2 overflows a 1024-word IMEM
    pulse_start();
    n0 = w_addr.size();
    send(32'h8000_0002);
    send(32'h0000_03FF);
    check("t4_err", 32'(err), 32'd1);
    check("t4_core_rst_n", 32'(core_rst_n), 32'd0);
    check("t4_s_ready", 32'(s_ready), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_imem_we", 32'(imem_we), 32'd0);
    tick(); tick();
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_no_writes", 32'(w_addr.size() - n0), 32'd0);
    pulse_start();
    check("t4_err_clr", 32'(err), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    // Exact fit at the top word is legal
    send(32'h8000_0001);
    send(32'h0000_03FF);
    send(32'hCAFE_F00D);
    check("t4_edge_we", 32'(imem_we), 32'd1);
    check("t4_edge_addr", 32'(imem_addr), 32'h3FF);
    check("t4_edge_data", imem_wdata, 32'hCAFE_F00D);
    tick();
    check("t4_edge_done", 32'(done), 32'd1);
    check("t4_edge_err", 32'(err), 32'd0);

    // Throttled 8-word DMEM block
    pulse_start();
    n0 = w_addr.size();
    send(32'hC000_0008);
    send(32'h0000_0020);
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int j = 0; j < gap; j++) tick();
      send(32'h0000_1000 + 32'(i));
    end
    tick();
    check("t5_done", 32'(done), 32'd1);
    check("t5_loaded", loaded_words, 32'd8);
    tick();
    check("t5_wr_count", 32'(w_addr.size() - n0), 32'd8);
    for (int i = 0; i < 8; i++) check_wr(n0 + i, 1'b1, 32'h20 + 32'(i), 32'h0000_1000 + 32'(i));

    // Reset mid-DATA after two of four words
    pulse_start();
    n0 = w_addr.size();
    send(32'h8000_0004);
    send(32'h0000_0040);
    send(32'h0000_00AA);
    send(32'h0000_00BB);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6");
    rst_n = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h0000_0055;
    tick(); tick();
    check("t6_ignored_ready", 32'(s_ready), 32'd0);
    check("t6_ignored_busy", 32'(busy), 32'd0);
    s_valid = 1'b0;
    check("t6_wr_count", 32'(w_addr.size() - n0), 32'd2);
    check_wr(n0 + 0, 1'b0, 32'h40, 32'h0000_00AA);
    check_wr(n0 + 1, 1'b0, 32'h41, 32'h0000_00BB);
    pulse_start();
    send(32'h8000_0000);
    send(32'h0000_0000);
    check("t6_recover_done", 32'(done), 32'd1);
    check("overlap_final", 32'(overlaps), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
